// File: rtl/dsp_inout_driver_if.sv
// ----------------------------------------------------------------------------
// dsp_inout_driver_if
//   Request/response bundle between an operation source and dsp_inout_driver.
//   Optional macro: DSP_DRIVER_TAG_EN adds req_tag / rsp_tag and TAG_WIDTH.
//
//   Signals
//     req_valid / req_ready   request handshake
//     req_a, req_b            operands (DATA_WIDTH/2 each)
//     req_m                   mode bit
//     req_tag                 request tag (DSP_DRIVER_TAG_EN only)
//     rsp_valid / rsp_ready   response handshake
//     rsp_data                result (DATA_WIDTH)
//     rsp_tag                 result tag (DSP_DRIVER_TAG_EN only)
//
//   Modports
//     master  the operation source / result consumer
//     slave   the driver
// ----------------------------------------------------------------------------
interface dsp_inout_driver_if #(
   parameter int unsigned DATA_WIDTH = 4
`ifdef DSP_DRIVER_TAG_EN
   , parameter int unsigned TAG_WIDTH = 3
`endif
);
   logic                      req_valid;
   logic                      req_ready;
   logic [DATA_WIDTH/2-1:0]   req_a;
   logic [DATA_WIDTH/2-1:0]   req_b;
   logic                      req_m;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [DATA_WIDTH-1:0]     rsp_data;
`ifdef DSP_DRIVER_TAG_EN
   logic [TAG_WIDTH-1:0]      req_tag;
   logic [TAG_WIDTH-1:0]      rsp_tag;

   modport master (
      output req_valid, req_a, req_b, req_m, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_tag
   );

   modport slave (
      input  req_valid, req_a, req_b, req_m, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_tag
   );
`else
   modport master (
      output req_valid, req_a, req_b, req_m, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_a, req_b, req_m, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
`endif
endinterface

// File: rtl/dsp_inout_driver.sv
// ----------------------------------------------------------------------------
// dsp_inout_driver
//   Initiator side of a registered-DSP operand interface. Requests are
//   forwarded combinationally to the DSP a/b/m inputs on acceptance; a valid
//   shift register tracks the fixed DSP latency, and each result is captured
//   into a circular result FIFO and returned in order. Requests are only
//   accepted while in-flight plus queued results fit in the FIFO, so the
//   stall-free DSP never produces a result with nowhere to go.
//
//   Optional macro: DSP_DRIVER_TAG_EN - carries a request tag through the
//   pipeline and FIFO alongside each result (adds TAG_WIDTH, req_tag, rsp_tag).
//
//   Ports
//     clk      clock shared with the DSP block
//     rst      synchronous, active-high reset
//     bus      dsp_inout_driver_if.slave: request / response handshakes
//     dsp_a    operand a to DSP (zero unless a request fires)
//     dsp_b    operand b to DSP (zero unless a request fires)
//     dsp_m    mode bit to DSP  (zero unless a request fires)
//     dsp_out  registered DSP result
// ----------------------------------------------------------------------------
module dsp_inout_driver #(
   parameter int unsigned DATA_WIDTH   = 4,
   parameter int unsigned DSP_LATENCY  = 2,
   parameter int unsigned RESULT_DEPTH = 4
`ifdef DSP_DRIVER_TAG_EN
   , parameter int unsigned TAG_WIDTH  = 3
`endif
) (
   input  logic                      clk,
   input  logic                      rst,
   dsp_inout_driver_if.slave         bus,
   output logic [DATA_WIDTH/2-1:0]   dsp_a,
   output logic [DATA_WIDTH/2-1:0]   dsp_b,
   output logic                      dsp_m,
   input  logic [DATA_WIDTH-1:0]     dsp_out
);

   localparam int unsigned PTR_W = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RESULT_DEPTH + 1);
   localparam int unsigned OCC_W = $clog2(DSP_LATENCY + RESULT_DEPTH + 1);

   logic                   req_fire;
   logic                   push;
   logic                   pop;
   logic                   rsp_valid;
   logic [OCC_W-1:0]       occ;

   logic [DSP_LATENCY-1:0] vld_q, vld_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  mem_q [RESULT_DEPTH];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RESULT_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit: every op already in the DSP pipeline has a FIFO slot reserved.
   // Built from registered state only, so a pop frees credit one cycle later.
   always_comb begin
      occ = OCC_W'(cnt_q);
      for (int unsigned i = 0; i < DSP_LATENCY; i++) begin
         occ = occ + OCC_W'(vld_q[i]);
      end
   end

   assign bus.req_ready = (occ < OCC_W'(RESULT_DEPTH));
   assign req_fire      = bus.req_valid & bus.req_ready;

   assign dsp_a = req_fire ? bus.req_a : '0;
   assign dsp_b = req_fire ? bus.req_b : '0;
   assign dsp_m = req_fire ? bus.req_m : 1'b0;

   // Top valid bit marks the cycle in which dsp_out carries that op's result.
   assign push      = vld_q[DSP_LATENCY-1];
   assign rsp_valid = (cnt_q != '0);
   assign pop       = rsp_valid & bus.rsp_ready;

   always_comb begin
      vld_d    = '0;
      vld_d[0] = req_fire;
      for (int unsigned i = 1; i < DSP_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
      end
   end

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      cnt_d    = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         vld_q    <= vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: nothing is visible unless the count says so.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= dsp_out;
      end
   end

   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = rsp_valid ? mem_q[rd_ptr_q] : '0;

`ifdef DSP_DRIVER_TAG_EN
   logic [TAG_WIDTH-1:0] tag_q     [DSP_LATENCY];
   logic [TAG_WIDTH-1:0] tag_mem_q [RESULT_DEPTH];

   // Tags ride alongside the valid bits; stale entries are never pushed.
   always_ff @(posedge clk) begin
      tag_q[0] <= bus.req_tag;
      for (int unsigned i = 1; i < DSP_LATENCY; i++) begin
         tag_q[i] <= tag_q[i-1];
      end
      if (push) begin
         tag_mem_q[wr_ptr_q] <= tag_q[DSP_LATENCY-1];
      end
   end

   assign bus.rsp_tag = rsp_valid ? tag_mem_q[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_dsp_inout_driver.sv
// ----------------------------------------------------------------------------
// tb_dsp_inout_driver
//   Pairs dsp_inout_driver with a two-register DSP model (input reg, output
//   reg) whose combinational function is model(): m=0 -> a*b, m=1 -> {a,b}.
// ----------------------------------------------------------------------------
module tb_dsp_inout_driver;

   localparam int unsigned DW = 4;

   logic clk;
   logic rst;
   logic [1:0] dsp_a, dsp_b;
   logic       dsp_m;
   logic [3:0] dsp_out;

   int checks = 0;
   int errors = 0;

`ifdef DSP_DRIVER_TAG_EN
   dsp_inout_driver_if #(.DATA_WIDTH(DW), .TAG_WIDTH(3)) bus ();
   dsp_inout_driver #(
      .DATA_WIDTH(DW), .DSP_LATENCY(2), .RESULT_DEPTH(4), .TAG_WIDTH(3)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_m(dsp_m), .dsp_out(dsp_out)
   );
`else
   dsp_inout_driver_if #(.DATA_WIDTH(DW)) bus ();
   dsp_inout_driver #(
      .DATA_WIDTH(DW), .DSP_LATENCY(2), .RESULT_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_m(dsp_m), .dsp_out(dsp_out)
   );
`endif

   function automatic logic [3:0] model(input logic [1:0] a, input logic [1:0] b, input logic m);
      return m ? {a, b} : ({2'b00, a} * {2'b00, b});
   endfunction

   // Registered DSP: input register then output register, no reset, no enable.
   logic [1:0] in_a_q, in_b_q;
   logic       in_m_q;
   always_ff @(posedge clk) begin
      in_a_q  <= dsp_a;
      in_b_q  <= dsp_b;
      in_m_q  <= dsp_m;
      dsp_out <= model(in_a_q, in_b_q, in_m_q);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [1:0] a;
      logic [1:0] b;
      logic       m;
      logic       rr;
      logic       e_rdy;
      logic [1:0] e_da;
      logic [1:0] e_db;
      logic       e_dm;
      logic       e_rv;
      logic [3:0] e_rd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, input logic [1:0] a, input logic [1:0] b,
                               input logic m, input logic rr, input logic e_rdy,
                               input logic e_rv, input logic [3:0] e_rd);
      vec_t t;
      logic fire;
      fire    = v & e_rdy;
      t.v     = v;
      t.a     = a;
      t.b     = b;
      t.m     = m;
      t.rr    = rr;
      t.e_rdy = e_rdy;
      t.e_da  = fire ? a : 2'd0;
      t.e_db  = fire ? b : 2'd0;
      t.e_dm  = fire ? m : 1'b0;
      t.e_rv  = e_rv;
      t.e_rd  = e_rd;
      return t;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] a, input logic [1:0] b,
                        input logic m, input logic rr);
      bus.req_valid = v;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_m     = m;
      bus.rsp_ready = rr;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] exp_d;
      logic       ev;

      rst = 1'b1;
      drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
`ifdef DSP_DRIVER_TAG_EN
      bus.req_tag = 3'd0;
`endif
      repeat (2) next_cycle();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_req_ready", int'(bus.req_ready), 1);
      chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
      chk("rst_rsp_data",  int'(bus.rsp_data), 0);
      chk("rst_dsp_a",     int'(dsp_a), 0);
      chk("rst_dsp_b",     int'(dsp_b), 0);
      chk("rst_dsp_m",     int'(dsp_m), 0);
`ifdef DSP_DRIVER_TAG_EN
      chk("rst_rsp_tag",   int'(bus.rsp_tag), 0);
`endif
      next_cycle();

      // Single op: accepted c0, visible c3, popped at the c3 edge
      vecs.push_back(mk(1, 2, 3, 0, 1, 1, 0, 4'd0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'd0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'd0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 4'd6));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'd0));

      // Backpressure: four accepts fill the credit, head held at model(0,1,1)=1
      vecs.push_back(mk(1, 0, 1, 1, 0, 1, 0, 4'd0));
      vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0, 4'd0));
      vecs.push_back(mk(1, 2, 1, 1, 0, 1, 0, 4'd0));
      vecs.push_back(mk(1, 3, 1, 1, 0, 1, 1, 4'd1));
      vecs.push_back(mk(1, 2, 2, 1, 0, 0, 1, 4'd1));
      vecs.push_back(mk(1, 2, 2, 1, 0, 0, 1, 4'd1));
      vecs.push_back(mk(1, 2, 2, 1, 0, 0, 1, 4'd1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'd1));   // pop; credit not back yet
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 4'd5));   // credit returns
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 4'd5));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 4'd9));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 4'd13));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'd0));

      // Streaming: 10 back-to-back ops, each result 3 cycles after its accept
      for (int n = 0; n < 14; n++) begin
         ev    = (n >= 3) && (n <= 12);
         exp_d = ev ? model(2'((n - 3) % 4), 2'((n - 2) % 4), 1'((n - 3) % 2)) : 4'd0;
         if (n < 10) begin
            vecs.push_back(mk(1, 2'(n % 4), 2'((n + 1) % 4), 1'(n % 2), 1, 1, ev, exp_d));
         end else begin
            vecs.push_back(mk(0, 0, 0, 0, 1, 1, ev, exp_d));
         end
      end

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].rr);
         @(negedge clk);
         chk($sformatf("v%0d_req_ready", i), int'(bus.req_ready), int'(vecs[i].e_rdy));
         chk($sformatf("v%0d_dsp_a", i),     int'(dsp_a),         int'(vecs[i].e_da));
         chk($sformatf("v%0d_dsp_b", i),     int'(dsp_b),         int'(vecs[i].e_db));
         chk($sformatf("v%0d_dsp_m", i),     int'(dsp_m),         int'(vecs[i].e_dm));
         chk($sformatf("v%0d_rsp_valid", i), int'(bus.rsp_valid), int'(vecs[i].e_rv));
         chk($sformatf("v%0d_rsp_data", i),  int'(bus.rsp_data),  int'(vecs[i].e_rd));
         next_cycle();
      end

      // Reset mid-operation: one result queued, two in flight
      for (int n = 0; n < 3; n++) begin
         drive(1'b1, 2'(n + 1), 2'(n + 1), 1'b1, 1'b0);
         next_cycle();
      end
      drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("midrst_pre_rsp_valid", int'(bus.rsp_valid), 1);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk($sformatf("midrst_c%0d_rsp_valid", n), int'(bus.rsp_valid), 0);
         chk($sformatf("midrst_c%0d_rsp_data", n),  int'(bus.rsp_data), 0);
         chk($sformatf("midrst_c%0d_req_ready", n), int'(bus.req_ready), 1);
         next_cycle();
      end

`ifdef DSP_DRIVER_TAG_EN
      begin
         int got;
         logic [3:0] exp_data [3];
         logic [2:0] exp_tag  [3];
         got = 0;
         for (int n = 0; n < 3; n++) begin
            exp_data[n] = model(2'(n + 1), 2'(n + 2), 1'b0);
            exp_tag[n]  = 3'(5 + n);
         end
         for (int c = 0; c < 20; c++) begin
            if (c < 3) begin
               drive(1'b1, 2'(c + 1), 2'(c + 2), 1'b0, 1'(c % 2 == 0));
               bus.req_tag = 3'(5 + c);
            end else begin
               drive(1'b0, 2'd0, 2'd0, 1'b0, 1'(c % 2 == 0));
               bus.req_tag = 3'd0;
            end
            @(negedge clk);
            if (c < 3) chk($sformatf("tag_c%0d_req_ready", c), int'(bus.req_ready), 1);
            if (bus.rsp_valid && bus.rsp_ready) begin
               if (got < 3) begin
                  chk($sformatf("tag_rsp%0d_data", got), int'(bus.rsp_data), int'(exp_data[got]));
                  chk($sformatf("tag_rsp%0d_tag", got),  int'(bus.rsp_tag),  int'(exp_tag[got]));
               end
               got++;
            end
            next_cycle();
         end
         chk("tag_rsp_count", got, 3);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
